// File: rtl/cache_pkg.sv
// Shared types and constants for the set-associative cache storage array.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP,
        WAIT_LOW
    } state_t;

    // Request mode, encoded as {comp, write}.
    localparam logic [1:0] ACC_RD = 2'b00;
    localparam logic [1:0] ACC_WR = 2'b01;
    localparam logic [1:0] CMP_RD = 2'b10;
    localparam logic [1:0] CMP_WR = 2'b11;

    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_plru.sv
// Per-set tree-PLRU state: one bit per internal tree node, heap-ordered (node 1 = root).
// A node bit points toward the less recently used subtree; WAYS=1 has no state.
module cache_plru
    import cache_pkg::*;
#(
    parameter int WAYS    = 2,
    parameter int INDEX_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INDEX_W-1:0]       i_index,
    input  logic                     i_touch,
    input  logic [way_w(WAYS)-1:0]   i_touch_way,
    output logic [way_w(WAYS)-1:0]   o_victim
);

    localparam int WW = way_w(WAYS);

    generate
        if (WAYS == 1) begin : g_single
            assign o_victim = '0;
        end else begin : g_tree
            localparam int LEVELS = $clog2(WAYS);
            localparam int NODES  = WAYS - 1;
            localparam int SETS   = 2 ** INDEX_W;

            logic [NODES-1:0] r_bits [SETS];
            logic [NODES-1:0] w_cur;
            logic [NODES-1:0] w_next;

            // NOTE: every always_comb output gets a default before any branch or loop,
            // otherwise a path that skips the assignment infers a latch.
            always_comb begin
                int node;
                w_cur = r_bits[i_index];
                node  = 1;
                for (int l = 0; l < LEVELS; l++) begin
                    node = 2 * node + int'(|(w_cur & (NODES'(1) << (node - 1))));
                end
                o_victim = WW'(node - WAYS);
            end

            // Walk root-to-leaf along the touched way, pointing each node away from it.
            always_comb begin
                int   node;
                logic dir;
                w_next = w_cur;
                node   = 1;
                for (int l = 0; l < LEVELS; l++) begin
                    dir    = |(i_touch_way & (WW'(1) << (LEVELS - 1 - l)));
                    w_next = (w_next & ~(NODES'(1) << (node - 1)))
                           | (NODES'(!dir) << (node - 1));
                    node   = 2 * node + int'(dir);
                end
            end

            // NOTE: clocked state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) r_bits[s] <= '0;
                end else if (i_touch) begin
                    r_bits[i_index] <= w_next;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cache_assoc.sv
// N-way set-associative cache storage with tree-PLRU replacement and a four-phase enable/ack handshake.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs for compare requests.
module cache_assoc
    import cache_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int WORD_W  = 2,
    parameter int TAG_W   = 5,
    parameter int DATA_W  = 16,
    parameter int WAYS    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [INDEX_W-1:0]     index,
    input  logic [WORD_W-1:0]      word,
    input  logic                   comp,
    input  logic                   write,
    input  logic [TAG_W-1:0]       tag_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   valid_in,
    output logic                   hit,
    output logic                   dirty,
    output logic [TAG_W-1:0]       tag_out,
    output logic [DATA_W-1:0]      data_out,
    output logic                   valid,
    output logic [way_w(WAYS)-1:0] way_out,
    output logic                   ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);

    localparam int SETS  = 2 ** INDEX_W;
    localparam int WORDS = 2 ** WORD_W;
    localparam int WW    = way_w(WAYS);

    state_t              r_state;
    logic [INDEX_W-1:0]  r_index;
    logic [WORD_W-1:0]   r_word;
    logic                r_comp;
    logic                r_write;
    logic [TAG_W-1:0]    r_tag_in;
    logic [DATA_W-1:0]   r_data_in;
    logic                r_valid_in;

    logic [TAG_W-1:0]    r_tag   [SETS][WAYS];
    logic [DATA_W-1:0]   r_data  [SETS][WAYS][WORDS];
    logic [WAYS-1:0]     r_valid_arr [SETS];
    logic [WAYS-1:0]     r_dirty_arr [SETS];

    logic [WAYS-1:0]     w_set_valid;
    logic [WAYS-1:0]     w_set_dirty;
    logic [WAYS-1:0]     w_match;
    logic [WW-1:0]       w_match_way;
    logic [WW-1:0]       w_invalid_way;
    logic [WW-1:0]       w_plru_victim;
    logic [WW-1:0]       w_victim;
    logic [WW-1:0]       w_sel;
    logic                w_hit;
    logic [1:0]          w_mode;
    logic                w_in_lookup;
    logic                w_wr_data;
    logic                w_wr_tag;
    logic                w_touch;
    logic [TAG_W-1:0]    w_sel_tag;
    logic [DATA_W-1:0]   w_sel_data;

    // Downward scan so the lowest-indexed match / invalid way is the one kept.
    always_comb begin
        w_set_valid   = r_valid_arr[r_index];
        w_set_dirty   = r_dirty_arr[r_index];
        w_match       = '0;
        w_match_way   = '0;
        w_invalid_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_match[w] = w_set_valid[w] && (r_tag[r_index][w] == r_tag_in);
            if (w_match[w])     w_match_way   = WW'(w);
            if (!w_set_valid[w]) w_invalid_way = WW'(w);
        end
        w_victim   = (&w_set_valid) ? w_plru_victim : w_invalid_way;
        w_hit      = r_comp && (|w_match);
        w_sel      = w_hit ? w_match_way : w_victim;
        w_sel_tag  = r_tag[r_index][w_sel];
        w_sel_data = r_data[r_index][w_sel][r_word];
    end

    assign w_mode      = {r_comp, r_write};
    assign w_in_lookup = (r_state == LOOKUP) && !rst;

    always_comb begin
        w_wr_data = 1'b0;
        w_wr_tag  = 1'b0;
        w_touch   = 1'b0;
        unique case (w_mode)
            CMP_RD: w_touch = w_hit;
            CMP_WR: begin
                w_wr_data = w_hit;
                w_touch   = w_hit;
            end
            ACC_WR: begin
                w_wr_data = 1'b1;
                w_wr_tag  = 1'b1;
                w_touch   = 1'b1;
            end
            ACC_RD: w_touch = 1'b0;
        endcase
        w_wr_data = w_wr_data && w_in_lookup;
        w_wr_tag  = w_wr_tag  && w_in_lookup;
        w_touch   = w_touch   && w_in_lookup;
    end

    cache_plru #(
        .WAYS    (WAYS),
        .INDEX_W (INDEX_W)
    ) u_plru (
        .clk         (clk),
        .rst         (rst),
        .i_index     (r_index),
        .i_touch     (w_touch),
        .i_touch_way (w_sel),
        .o_victim    (w_plru_victim)
    );

    // NOTE: tag and data RAMs carry no reset; the valid bits make their contents irrelevant
    // after reset, and leaving them unreset keeps them mappable to plain memory.
    always_ff @(posedge clk) begin
        if (w_wr_data) r_data[r_index][w_sel][r_word] <= r_data_in;
        if (w_wr_tag)  r_tag[r_index][w_sel]          <= r_tag_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid_arr[s] <= '0;
                r_dirty_arr[s] <= '0;
            end
        end else if (w_wr_data) begin
            if (w_wr_tag) begin
                r_valid_arr[r_index][w_sel] <= r_valid_in;
                r_dirty_arr[r_index][w_sel] <= 1'b0;
            end else begin
                r_dirty_arr[r_index][w_sel] <= 1'b1;
            end
        end
    end

    // Outputs report the selected way as it stands once this request's write has landed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_word     <= '0;
            r_comp     <= 1'b0;
            r_write    <= 1'b0;
            r_tag_in   <= '0;
            r_data_in  <= '0;
            r_valid_in <= 1'b0;
            hit        <= 1'b0;
            dirty      <= 1'b0;
            tag_out    <= '0;
            data_out   <= '0;
            valid      <= 1'b0;
            way_out    <= '0;
            ack        <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_index    <= index;
                        r_word     <= word;
                        r_comp     <= comp;
                        r_write    <= write;
                        r_tag_in   <= tag_in;
                        r_data_in  <= data_in;
                        r_valid_in <= valid_in;
                        r_state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    hit      <= w_hit;
                    way_out  <= w_sel;
                    tag_out  <= w_wr_tag  ? r_tag_in   : w_sel_tag;
                    valid    <= w_wr_tag  ? r_valid_in : w_set_valid[w_sel];
                    dirty    <= w_wr_data ? r_comp     : w_set_dirty[w_sel];
                    data_out <= w_wr_data ? r_data_in  : w_sel_data;
                    ack      <= 1'b1;
                    r_state  <= RESP;
                end
                RESP: begin
                    ack     <= 1'b0;
                    r_state <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!enable) r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == RESP && r_comp) begin
            if (hit && hit_count != 16'hFFFF)         hit_count  <= hit_count + 16'd1;
            else if (!hit && miss_count != 16'hFFFF)  miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: doc/cache_assoc.md
Name: cache_assoc

Overview:
- Parametrised N-way set-associative cache storage array: tag, valid, dirty and data arrays plus tree-PLRU replacement.
- Successor to the direct-mapped set-array cache. Keeps the same request modes (comp/write) and enable/ack four-phase handshake, but is fully synchronous and adds associativity, replacement and a reported way.
- Sits between the cache controller FSM and the memory side; the controller issues one request at a time.

Parameters:
- INDEX_W, 4, set index width (2^INDEX_W sets)
- WORD_W, 2, word-in-line offset width (2^WORD_W words per line)
- TAG_W, 5, tag width
- DATA_W, 16, word width
- WAYS, 2, associativity; power of two, 1..8

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- enable  in  1  request strobe; level, held until ack seen
- index  in  INDEX_W  set select
- word  in  WORD_W  word select
- comp  in  1  1 = compare (tag lookup), 0 = direct access to victim way
- write  in  1  1 = write, 0 = read
- tag_in  in  TAG_W  tag for compare / tag to install
- data_in  in  DATA_W  write data
- valid_in  in  1  valid bit installed on access-write
- hit  out  1  tag matched in a valid way (compare modes only)
- dirty  out  1  dirty bit of the selected way
- tag_out  out  TAG_W  tag of the selected way
- data_out  out  DATA_W  word of the selected way
- valid  out  1  valid bit of the selected way
- way_out  out  max(1,log2 WAYS)  selected way
- ack  out  1  one-cycle response strobe

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst).
- Reset:
  - clears all valid, dirty and PLRU bits; data and tag arrays are not cleared.
  - state→IDLE; all outputs 0.
  - rst wins over a simultaneous enable. rst mid-request aborts it: no array write, no ack.
- FSM: IDLE →(enable) LOOKUP → RESP → WAIT_LOW →(!enable) IDLE.
  - IDLE registers index, word, comp, write, tag_in, data_in and valid_in.
  - LOOKUP reads the set, selects the way and commits any write at the end of the cycle.
  - RESP drives registered outputs and ack=1 for exactly one cycle.
  - WAIT_LOW holds until enable=0 (four-phase handshake).
  - Latency: enable rise at cycle 0 → ack at cycle 2. Outputs hold until the next RESP.
- Selected way:
  - compare modes: the matching way on hit, else the victim.
  - access modes: always the victim.
- Victim = lowest-indexed invalid way, else the tree-PLRU choice.
- Modes (comp, write):
  - (1,0) compare-read: on hit, returns the word and touches PLRU. On miss, hit=0 and tag_out/dirty/valid describe the victim for writeback.
  - (1,1) compare-write: on hit, writes data_in to the word, sets dirty=1 and touches PLRU. On miss, the array is unchanged and hit=0.
  - (0,0) access-read: returns the victim way's word, tag, valid and dirty; hit=0; PLRU unchanged.
  - (0,1) access-write: writes the word into the victim way, sets tag=tag_in, valid=valid_in, dirty=0, and touches PLRU; hit=0.
- More than one matching valid way cannot arise legally; if it does, the lowest index wins.
- Because an access-read does not update PLRU, it returns the same victim as the preceding compare miss on that index.
- WAYS=1: PLRU logic absent; victim is always 0; way_out=0.
- Requests are ignored outside IDLE.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs hit_count[15:0] and miss_count[15:0]. These count compare requests (hit or miss) at RESP, saturate at 0xFFFF and clear on rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package cache_pkg holds:
  - state enum (IDLE, LOOKUP, RESP, WAIT_LOW)
  - mode encoding constants (ACC_RD, ACC_WR, CMP_RD, CMP_WR)
  - helper function for the way-select width
- Sub-module cache_plru: per-set tree-PLRU bit storage with a victim output, a touch(way) update and a reset clear; parametrised by WAYS and INDEX_W.

Test Plan:
- Reset, then compare-read at index 3, tag 0x05 → ack at cycle 2, hit=0, valid=0, way_out=0.
- Access-write index 3, word 1, tag 0x05, data 0xBEEF, valid_in 1; then compare-read of the same address → hit=1, data_out=0xBEEF, dirty=0, way_out=0.
- Compare-write 0x1234 to that hit; then access-read index 3 after filling way 1 with tag 0x0A and touching way 1 → way_out=0, dirty=1, tag_out=0x05.
- Fill both ways of index 7 (tags 0x01, 0x02), touch tag 0x01, then compare-read tag 0x03 → hit=0, way_out=1, tag_out=0x02.
- Assert rst during LOOKUP of an access-write → no ack; a later compare-read of that address → hit=0, valid=0.
- Hold enable high after ack → no second ack until enable drops and re-rises. With CACHE_STATS_EN: 3 hits and 2 misses → hit_count=3, miss_count=2.
